// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and the PC sequencer state type.
package mips_pkg;

  // Datapath word width
  localparam int unsigned WORD_W = 32;

  // Sequential PC step: one 32-bit instruction word
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;

  // PC sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  // True when an address sits on a word boundary
  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and fetch-request outputs of the PC unit.
// The slave modport is the PC unit's view; the master modport is the driver's view.
interface pc_unit_if #(
  parameter int CNT_W = 16
) ();

  logic                         start;
  logic [mips_pkg::WORD_W-1:0]  next_pc;
  logic                         stall;
  logic                         halt_req;
  logic                         ready;
  logic [mips_pkg::WORD_W-1:0]  pc;
  logic [mips_pkg::WORD_W-1:0]  pc_plus4;
  logic                         valid;
  logic                         halted;
  logic                         misalign;
  logic [CNT_W-1:0]             fetch_count;

  modport master (
    output start, next_pc, stall, halt_req, ready,
    input  pc, pc_plus4, valid, halted, misalign, fetch_count
  );

  modport slave (
    input  start, next_pc, stall, halt_req, ready,
    output pc, pc_plus4, valid, halted, misalign, fetch_count
  );

endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with IDLE/RUN/STALL/HALT sequencing, a fetch
// handshake (valid/ready) and an accepted-fetch counter.
// Optional feature macro: PC_ALIGN_CHECK_EN -- when defined, a misaligned
// advance target halts the unit and raises the sticky misalign flag; when
// undefined, targets are forced onto a word boundary and misalign stays 0.
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int                CNT_W        = 16
) (
  input logic        clk,
  input logic        reset,
  pc_unit_if.slave   bus
);

  pc_state_t          state_r;
  pc_state_t          state_next_s;
  logic [WORD_W-1:0]  pc_r;
  logic [WORD_W-1:0]  pc_load_s;
  logic [CNT_W-1:0]   count_r;
  logic               valid_r;
  logic               halted_r;
  logic               advance_s;
  logic               bad_target_s;
  logic               take_s;

  // Fetch acceptance and target legality for the current cycle
  always_comb begin
    advance_s = (state_r == RUN) & bus.ready & ~bus.stall & ~bus.halt_req;
`ifdef PC_ALIGN_CHECK_EN
    bad_target_s = advance_s & ~is_word_aligned(bus.next_pc);
    pc_load_s    = bus.next_pc;
`else
    bad_target_s = 1'b0;
    pc_load_s    = {bus.next_pc[WORD_W-1:2], 2'b00};
`endif
    take_s = advance_s & ~bad_target_s;
  end

  // Next-state selection: halt_req beats stall beats advance
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.halt_req) begin
          state_next_s = HALT;
        end else if (bus.start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_next_s = HALT;
        end else if (bus.stall) begin
          state_next_s = STALL;
        end else if (bad_target_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      STALL: begin
        if (bus.halt_req) begin
          state_next_s = HALT;
        end else if (!bus.stall) begin
          state_next_s = RUN;
        end else begin
          state_next_s = STALL;
        end
      end
      HALT: begin
        state_next_s = HALT;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register plus status outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      valid_r  <= (state_next_s == RUN);
      halted_r <= (state_next_s == HALT);
    end
  end

  // PC and accepted-fetch counter update on a legal advance only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r    <= RESET_VECTOR;
      count_r <= {CNT_W{1'b0}};
    end else if (take_s) begin
      pc_r    <= pc_load_s;
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pc_r    <= pc_r;
      count_r <= count_r;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_r;

  // Sticky misaligned-target flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_r <= 1'b0;
    end else if (bad_target_s) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign bus.misalign = misalign_r;
`else
  assign bus.misalign = 1'b0;
`endif

  assign bus.pc          = pc_r;
  assign bus.pc_plus4    = pc_r + PC_INC;
  assign bus.valid       = valid_r;
  assign bus.halted      = halted_r;
  assign bus.fetch_count = count_r;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter CNT_W, 16, the width of fetch_count.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  leaves IDLE and begins fetching.
REQ-006 Port next_pc  input  32  selected next PC, driven by the 32-bit next-PC 2:1 mux output.
REQ-007 Port stall  input  1  freezes the PC and deasserts valid while high.
REQ-008 Port halt_req  input  1  requests a permanent halt.
REQ-009 Port ready  input  1  the downstream fetch/IF-ID stage accepts the current pc.
REQ-010 Port pc  output  32  current PC, registered.
REQ-011 Port pc_plus4  output  32  pc + 4, combinational; this is the sequential input of the next-PC mux.
REQ-012 Port valid  output  1  pc is a fetch request.
REQ-013 Port halted  output  1  the block is in HALT.
REQ-014 Port misalign  output  1  sticky misaligned-target flag (see Configuration).
REQ-015 Port fetch_count  output  CNT_W  number of accepted fetches.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RUN, STALL, HALT.
REQ-017 Priority in RUN/STALL SHALL be halt_req > stall > advance.
REQ-018 IDLE: valid=0 and pc is held.
  - halt_req=1 -> HALT.
  - else start=1 -> RUN on the next edge.
REQ-019 RUN: valid=1; advance = ready & ~stall & ~halt_req.
  - On advance, pc <= next_pc and fetch_count increments, effective the next cycle.
REQ-020 RUN with ready=0 (and no stall/halt) SHALL hold pc stable with valid=1 until ready=1.
REQ-021 RUN with stall=1 -> STALL; pc is not updated in that cycle.
REQ-022 STALL: valid=0 and pc is held.
  - stall=0 -> RUN.
  - halt_req=1 -> HALT.
REQ-023 HALT: valid=0, halted=1, pc and fetch_count frozen; HALT is exited only by reset.
REQ-024 pc_plus4 SHALL be pc + 4 modulo 2^32, so 32'hFFFF_FFFC yields 32'h0000_0000.
REQ-025 fetch_count SHALL wrap from all-ones to zero with no flag.
REQ-026 Latency: a next_pc value presented in an advance cycle SHALL appear on pc exactly one clock later.

Reset
REQ-027 Reset SHALL act immediately, regardless of clk or current state, including mid-STALL and HALT.
REQ-028 Reset values SHALL be: state=IDLE, pc=RESET_VECTOR, valid=0, halted=0, misalign=0, fetch_count=0.
REQ-029 On reset release, the block SHALL stay in IDLE until start=1.

Configuration
REQ-030 Macro PC_ALIGN_CHECK_EN SHALL control target-alignment checking.
  - Defined: an advance with next_pc[1:0] != 2'b00 SHALL leave pc unchanged and not count the fetch; misalign<=1 (sticky until reset) and the state goes to HALT.
  - Undefined: misalign is tied 0, and pc SHALL load {next_pc[31:2], 2'b00}.

Structure
REQ-031 Shared package mips_pkg SHALL hold:
  - the 32-bit word-width constant;
  - the PC increment constant 4;
  - the pc_state_t enumeration (IDLE, RUN, STALL, HALT).
REQ-032 The FSM and datapath SHALL be in one module, with no sub-module; the pc_plus4 adder is inline.

Verification
REQ-033 Reset then start=1, ready=1, next_pc driven by the mux from pc_plus4 for 4 cycles -> pc goes 0,4,8,12,16 and fetch_count=4.
REQ-034 In RUN, ready=0 for 3 cycles with next_pc=32'h40 -> pc held and valid=1; when ready=1, pc=32'h40 on the next edge.
REQ-035 stall=1 for 2 cycles at pc=8 -> valid=0 and pc=8 throughout; when stall=0, valid=1 and advance resumes from 8.
REQ-036 halt_req and stall asserted together in RUN -> HALT, halted=1; further start/ready are ignored until reset returns pc=RESET_VECTOR.
REQ-037 next_pc=32'h0000_0042 on advance:
  - with PC_ALIGN_CHECK_EN -> misalign=1, HALT, pc unchanged;
  - without it -> pc=32'h0000_0040.
REQ-038 pc=32'hFFFF_FFFC -> pc_plus4=0; with fetch_count forced near 16'hFFFF, advancing -> fetch_count wraps to 0.
